// File: rtl/morph_pkg.sv
// Shared definitions for the streaming 3x3 morphology stages (erosion and dilation).
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a. Contents: FSM state codes, default frame size, counter widths.
package morph_pkg;

    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_COL_W = cnt_w(DEF_WIDTH);
    localparam int DEF_ROW_W = cnt_w(DEF_HEIGHT);

    // Frame-sequencing states.
    typedef logic [1:0] state_t;
    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/morph_erosion3x3_if.sv
// Pixel-stream bundle between a mask producer and a 3x3 morphology stage.
// Latency: n/a (wiring only).
// Backpressure: producer must hold off iDVAL while oBUSY is high; oERR flags violations.
// Ports: iDATA/iDVAL (mask in), oDATA/oDVAL (result out), oBUSY (flushing), oERR (sticky).
interface morph_erosion3x3_if;
    logic iDATA;
    logic iDVAL;
    logic oDATA;
    logic oDVAL;
    logic oBUSY;
    logic oERR;

    modport master (
        output iDATA, iDVAL,
        input  oDATA, oDVAL, oBUSY, oERR
    );

    modport slave (
        input  iDATA, iDVAL,
        output oDATA, oDVAL, oBUSY, oERR
    );
endinterface

// File: rtl/morph_line_buffer.sv
// Two-tap 1-bit line buffer: outputs the bit accepted DEPTH and 2*DEPTH enables ago.
// Latency: taps reflect history up to the last enabled edge; no added pipeline stage.
// Backpressure: none; shifts only when en is high. Storage is deliberately not reset.
// Ports: clk, en (shift enable), din, tap_w (din delayed DEPTH), tap_2w (delayed 2*DEPTH).
module morph_line_buffer #(
    parameter int DEPTH = 320
) (
    input  logic clk,
    input  logic en,
    input  logic din,
    output logic tap_w,
    output logic tap_2w
);
    logic [2*DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (en) begin
            sr <= {sr[2*DEPTH-2:0], din};
        end
    end

    // Before the shift, sr[j] holds the bit accepted j+1 enables ago.
    assign tap_w  = sr[DEPTH-1];
    assign tap_2w = sr[2*DEPTH-1];
endmodule

// File: rtl/morph_erosion3x3.sv
// 3x3 binary erosion of a raster-order mask stream; one output bit per input pixel.
// Latency: 1 cycle from accepting pixel k to emitting center k-(W+1); W+1 flush outputs at frame end.
// Backpressure: none downstream; oBUSY marks the flush, iDVAL then is dropped and sets sticky oERR.
// Ports: iclk, irst (async, active-high), bus (slave side of morph_erosion3x3_if).
// Build option: define ERODE_CROSS_EN for a plus-shaped element (corners ignored); default is 3x3 square.
module morph_erosion3x3
    import morph_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_WIDTH,
    parameter int IMG_HEIGHT = DEF_HEIGHT
) (
    input  logic              iclk,
    input  logic              irst,
    morph_erosion3x3_if.slave bus
);
    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam int FW = cnt_w(IMG_WIDTH + 1);

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [CW-1:0]   ccol;
    logic [RW-1:0]   crow;
    logic [CW-1:0]   ccol_nx;
    logic [RW-1:0]   crow_nx;
    logic [FW-1:0]   fcnt;
    // win[c][r]: c=0 left .. 2 right, r=2 top (2W tap) .. 0 bottom (live pixel).
    logic [2:0][2:0] win;
    logic            dval_q;
    logic            res_q;
    logic            busy_q;
    logic            err_q;
    logic            tap_w;
    logic            tap_2w;
    logic            accept;
    logic            last_px;
    logic            border;
    logic            emit;
    logic            win_and;

    assign accept  = bus.iDVAL && (state != ST_FLUSH);
    assign last_px = (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
    assign emit    = ((state == ST_RUN) && accept) || (state == ST_FLUSH);

    // Border status comes from the center counters, so wrapped window
    // columns at line edges never leak into the result.
    assign border = (crow == '0) || (crow == RW'(IMG_HEIGHT - 1)) ||
                    (ccol == '0) || (ccol == CW'(IMG_WIDTH - 1));

    always_comb begin
        ccol_nx = ccol + 1'b1;
        crow_nx = crow;
        if (ccol == CW'(IMG_WIDTH - 1)) begin
            ccol_nx = '0;
            crow_nx = (crow == RW'(IMG_HEIGHT - 1)) ? '0 : crow + 1'b1;
        end
    end

    morph_line_buffer #(.DEPTH(IMG_WIDTH)) u_lbuf (
        .clk    (iclk),
        .en     (accept),
        .din    (bus.iDATA),
        .tap_w  (tap_w),
        .tap_2w (tap_2w)
    );

`ifdef ERODE_CROSS_EN
    assign win_and = win[1][2] & win[1][1] & win[1][0] & win[0][1] & win[2][1];
`else
    assign win_and = &win;
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state  <= ST_FILL;
            col    <= '0;
            row    <= '0;
            ccol   <= '0;
            crow   <= '0;
            fcnt   <= '0;
            win    <= '0;
            dval_q <= 1'b0;
            res_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dval_q <= 1'b0;
            res_q  <= 1'b0;
            busy_q <= 1'b0;
            if (bus.iDVAL && (state == ST_FLUSH)) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                win <= {{tap_2w, tap_w, bus.iDATA}, win[2], win[1]};
                if (col == CW'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (emit) begin
                dval_q <= 1'b1;
                ccol   <= ccol_nx;
                crow   <= crow_nx;
            end
            case (state)
                // Pixel k=W (row 1, col 0) is the last one that has no center yet.
                ST_FILL: begin
                    if (accept && (row == RW'(1)) && (col == '0)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        res_q <= !border;
                        if (last_px) begin
                            state <= ST_FLUSH;
                            fcnt  <= '0;
                        end
                    end
                end
                // The remaining W+1 centers are all on the border, so emit zeros.
                ST_FLUSH: begin
                    busy_q <= 1'b1;
                    if (fcnt == FW'(IMG_WIDTH)) begin
                        state <= ST_FILL;
                        fcnt  <= '0;
                        ccol  <= '0;
                        crow  <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    // Window is already centered after the accept edge; res_q gates border and idle cycles.
    assign bus.oDATA = res_q & win_and;
    assign bus.oDVAL = dval_q;
    assign bus.oBUSY = busy_q;
    assign bus.oERR  = err_q;
endmodule
